// File: rtl/downcount_pkg.sv
// Shared constants and types for the down counter controller slice.
package downcount_pkg;
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_TICK_DIV = 1;
  localparam int DIV_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/dcnt_core.sv
// Loadable down counter. Load has priority over enable; the controller
// clears the counter by loading zero.
module dcnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);
  // counter register: load wins, else decrement when enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count - WIDTH'(1);
  end

  assign is_one = (count == WIDTH'(1));
endmodule

// File: rtl/downcount_ctrl.sv
// Sequencing controller for the down counter core: start/load, tick
// pacing, pause/resume, abort, auto-reload and terminal-count pulse.
module downcount_ctrl
  import downcount_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  state_e             state, state_n;
  logic [DIV_W-1:0]   div, div_n;
  logic [WIDTH-1:0]   reload, reload_n;
  logic               done_n;
  logic               ld, en, is_one;
  logic [WIDTH-1:0]   ld_val;

  // Next-state decode, priority abort > start > pause > tick. A HOLD cycle
  // with pause released already behaves as a RUN cycle, so each paused
  // cycle costs exactly one cycle of completion time.
  always_comb begin
    state_n  = state;
    div_n    = div;
    reload_n = reload;
    done_n   = 1'b0;
    ld       = 1'b0;
    ld_val   = '0;
    en       = 1'b0;
    if (abort) begin
      state_n = IDLE;
      div_n   = '0;
      ld      = 1'b1;
    end else if (state == IDLE) begin
      if (start) begin
        if (load_val != '0) begin
          ld       = 1'b1;
          ld_val   = load_val;
          reload_n = load_val;
          div_n    = '0;
          state_n  = RUN;
        end else begin
          done_n = 1'b1;
        end
      end
    end else if (pause) begin
      state_n = HOLD;
    end else begin
      state_n = RUN;
      if (div == DIV_MAX) begin
        div_n = '0;
        if (is_one) begin
          done_n = 1'b1;
          ld     = 1'b1;
          if (auto_reload) ld_val = reload;
          else             state_n = IDLE;
        end else begin
          en = 1'b1;
        end
      end else begin
        div_n = div + DIV_W'(1);
      end
    end
  end

  // control state and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      div    <= '0;
      reload <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      div    <= div_n;
      reload <= reload_n;
      done   <= done_n;
      busy   <= (state_n != IDLE);
    end
  end

  dcnt_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .en       (en),
    .count    (count),
    .is_one   (is_one)
  );
endmodule

// File: tb/tb_downcount_ctrl.sv
// Directed bench: one DUT at TICK_DIV=1 and one at TICK_DIV=3, sharing all
// inputs except start.
module tb_downcount_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] load_val = '0;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic       pause = 1'b0, abort = 1'b0, auto_reload = 1'b0;
  logic [3:0] count1, count3;
  logic       busy1, busy3, done1, done3;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  downcount_ctrl #(.WIDTH(4), .TICK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start1), .pause(pause),
    .abort(abort), .auto_reload(auto_reload), .count(count1), .busy(busy1),
    .done(done1));

  downcount_ctrl #(.WIDTH(4), .TICK_DIV(3)) u3 (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start3), .pause(pause),
    .abort(abort), .auto_reload(auto_reload), .count(count3), .busy(busy3),
    .done(done3));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [3:0] c, input logic b, input logic d);
    chk({tag, ".count"}, 32'(count1), 32'(c));
    chk({tag, ".busy"},  32'(busy1),  32'(b));
    chk({tag, ".done"},  32'(done1),  32'(d));
  endtask

  initial begin
    #3;
    chk1("reset", 4'd0, 1'b0, 1'b0);
    chk({"reset3.count"}, 32'(count3), 32'd0);
    #9 rst = 1'b1;

    // TICK_DIV=1, load 5, no reload
    load_val = 4'd5; start1 = 1'b1;
    cyc; start1 = 1'b0;
    chk1("t1.load", 4'd5, 1'b1, 1'b0);
    for (int v = 4; v >= 1; v--) begin
      cyc; chk1("t1.dec", 4'(v), 1'b1, 1'b0);
    end
    cyc; chk1("t1.term", 4'd0, 1'b0, 1'b1);
    cyc; chk1("t1.after", 4'd0, 1'b0, 1'b0);

    // TICK_DIV=3, load 2: decrement at k+3, done at k+6
    load_val = 4'd2; start3 = 1'b1;
    cyc; start3 = 1'b0;
    chk("t2.load", 32'(count3), 32'd2);
    chk("t2.busy", 32'(busy3), 32'd1);
    cyc; chk("t2.c1", 32'(count3), 32'd2);
    cyc; chk("t2.c2", 32'(count3), 32'd2);
    cyc; chk("t2.c3", 32'(count3), 32'd1);
    cyc; chk("t2.c4", 32'(count3), 32'd1);
    chk("t2.nodone", 32'(done3), 32'd0);
    cyc; chk("t2.c5", 32'(count3), 32'd1);
    cyc; chk("t2.c6", 32'(count3), 32'd0);
    chk("t2.done", 32'(done3), 32'd1);
    chk("t2.idle", 32'(busy3), 32'd0);
    cyc; chk("t2.pulse", 32'(done3), 32'd0);

    // auto-reload, load 3, ten periods
    load_val = 4'd3; auto_reload = 1'b1; start1 = 1'b1;
    cyc; start1 = 1'b0;
    chk1("t3.load", 4'd3, 1'b1, 1'b0);
    for (int p = 0; p < 10; p++) begin
      cyc; chk1("t3.two", 4'd2, 1'b1, 1'b0);
      cyc; chk1("t3.one", 4'd1, 1'b1, 1'b0);
      cyc; chk1("t3.reload", 4'd3, 1'b1, 1'b1);
    end
    abort = 1'b1; auto_reload = 1'b0;
    cyc; abort = 1'b0;
    chk1("t3.abort", 4'd0, 1'b0, 1'b0);

    // pause for 5 cycles: done moves from k+4 to k+9
    load_val = 4'd4; start1 = 1'b1;
    cyc; start1 = 1'b0;
    chk1("t4.load", 4'd4, 1'b1, 1'b0);
    cyc; chk1("t4.dec", 4'd3, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc; chk1("t4.hold", 4'd3, 1'b1, 1'b0);
    end
    pause = 1'b0;
    cyc; chk1("t4.res2", 4'd2, 1'b1, 1'b0);
    cyc; chk1("t4.res1", 4'd1, 1'b1, 1'b0);
    cyc; chk1("t4.term", 4'd0, 1'b0, 1'b1);

    // abort while in HOLD
    load_val = 4'd4; start1 = 1'b1;
    cyc; start1 = 1'b0;
    pause = 1'b1;
    cyc; chk1("t4b.hold", 4'd4, 1'b1, 1'b0);
    abort = 1'b1;
    cyc; chk1("t4b.abort", 4'd0, 1'b0, 1'b0);
    abort = 1'b0; pause = 1'b0;
    cyc; chk1("t4b.nodone", 4'd0, 1'b0, 1'b0);

    // start+abort in IDLE, then start ignored while running
    load_val = 4'd7; start1 = 1'b1; abort = 1'b1;
    cyc; abort = 1'b0;
    chk1("t5.startabort", 4'd0, 1'b0, 1'b0);
    cyc; chk1("t5.load", 4'd7, 1'b1, 1'b0);
    load_val = 4'd2;
    cyc; chk1("t5.ign1", 4'd6, 1'b1, 1'b0);
    cyc; chk1("t5.ign2", 4'd5, 1'b1, 1'b0);
    start1 = 1'b0; abort = 1'b1;
    cyc; abort = 1'b0;
    chk1("t5.clr", 4'd0, 1'b0, 1'b0);

    // zero load value
    load_val = 4'd0; start1 = 1'b1;
    cyc; start1 = 1'b0;
    chk1("t6.zero", 4'd0, 1'b0, 1'b1);
    cyc; chk1("t6.after", 4'd0, 1'b0, 1'b0);

    // asynchronous reset mid-run, then restart
    load_val = 4'd9; start1 = 1'b1;
    cyc; start1 = 1'b0;
    chk1("t7.load", 4'd9, 1'b1, 1'b0);
    cyc; chk1("t7.dec", 4'd8, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 chk1("t7.async", 4'd0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    load_val = 4'd2; start1 = 1'b1;
    cyc; start1 = 1'b0;
    chk1("t7.reload", 4'd2, 1'b1, 1'b0);
    cyc; chk1("t7.dec2", 4'd1, 1'b1, 1'b0);
    cyc; chk1("t7.term", 4'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
